// File: rtl/match_pkg.sv
// Shared types and helpers for the round/match sequencer.
package match_pkg;

    typedef enum logic [2:0] {
        TITLE,
        COUNTDOWN,
        FIGHT,
        ROUND_END,
        MATCH_END
    } match_state_t;

    // hp_state and match_winner share one encoding
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } win_code_t;

    localparam logic [1:0] COUNTDOWN_START = 2'd3;

    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] cap);
        return (value == cap) ? value : value + 3'd1;
    endfunction

    // A side at the target wins outright; otherwise (round cap) the higher count wins
    function automatic win_code_t pick_winner(input logic [2:0] p1, input logic [2:0] p2,
                                              input logic [2:0] target);
        if (p1 == target)   return WIN_P1;
        if (p2 == target)   return WIN_P2;
        if (p1 > p2)        return WIN_P1;
        if (p2 > p1)        return WIN_P2;
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/match_controller_tick_second_counter.sv
// Divides the game tick strobe down to one pulse per displayed second.
module tick_second_counter #(
    parameter int TICKS_PER_SEC = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_en,
    input  logic clear,
    output logic sec_pulse
);

    localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (tick_en)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    // Not gated by clear, so the FSM can use it to decide its own transitions
    assign sec_pulse = tick_en && (count == LAST);

endmodule

// File: rtl/match_controller.sv
// Best-of-N round/match sequencer: countdown, fight, round-end and match-end holds, scoring.
// Define ROUND_TIMER_EN to build the round timer; otherwise only hp_state ends a round.
module match_controller
    import match_pkg::*;
#(
    parameter int TICKS_PER_SEC = 20,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int MAX_ROUNDS    = 5,
    parameter int ROUND_SECS    = 99,
    parameter int HOLD_TICKS    = 40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_en,
    input  logic [1:0] hp_state,
    input  logic [8:0] health_1,
    input  logic [8:0] health_2,
    input  logic       confirm_btn,
    input  logic       force_reset,
    output logic       round_reset,
    output logic       controls_en,
    output logic [2:0] p1_rounds,
    output logic [2:0] p2_rounds,
    output logic [2:0] round_num,
    output logic [6:0] timer_secs,
    output logic [1:0] countdown,
    output logic [1:0] match_winner
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [2:0] RTW       = 3'(ROUNDS_TO_WIN);
    localparam logic [2:0] MAXR      = 3'(MAX_ROUNDS);
    localparam logic [6:0] SECS_INIT = 7'(ROUND_SECS);

    match_state_t  state, state_nx;
    logic [1:0]    countdown_nx;
    logic [2:0]    p1_nx, p2_nx, round_nx;
    win_code_t     winner_nx;
    logic          round_reset_nx, controls_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [HW-1:0] force_cnt, force_nx;
    logic          go_title;
    logic          timeout;
    logic          sec_pulse;
    logic          sub_clear;

    assign sub_clear = tick_en && (state_nx != state);

    tick_second_counter #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_en   (tick_en),
        .clear     (sub_clear),
        .sec_pulse (sec_pulse)
    );

`ifdef ROUND_TIMER_EN
    logic [6:0] timer_q, timer_nx;

    // Timeout fires on the tick the timer would reach zero
    assign timeout = (timer_q == 7'd0) || (sec_pulse && timer_q == 7'd1);

    always_comb begin
        timer_nx = timer_q;
        if (tick_en) begin
            if (go_title || (state == COUNTDOWN && state_nx == FIGHT))
                timer_nx = SECS_INIT;
            else if (state == FIGHT && sec_pulse && timer_q != 7'd0)
                timer_nx = timer_q - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            timer_q <= SECS_INIT;
        else
            timer_q <= timer_nx;
    end

    assign timer_secs = timer_q;
`else
    assign timeout    = 1'b0;
    assign timer_secs = SECS_INIT;
`endif

    always_comb begin
        state_nx       = state;
        countdown_nx   = countdown;
        p1_nx          = p1_rounds;
        p2_nx          = p2_rounds;
        round_nx       = round_num;
        winner_nx      = win_code_t'(match_winner);
        round_reset_nx = round_reset;
        controls_nx    = controls_en;
        hold_nx        = hold_cnt;
        force_nx       = force_cnt;
        go_title       = 1'b0;

        if (tick_en) begin
            force_nx = force_reset ? force_cnt + 1'b1 : '0;

            case (state)
                TITLE: begin
                    round_reset_nx = 1'b1;
                    if (confirm_btn) begin
                        state_nx       = COUNTDOWN;
                        countdown_nx   = COUNTDOWN_START;
                        round_reset_nx = 1'b0;
                    end
                end
                COUNTDOWN: begin
                    round_reset_nx = 1'b0;
                    if (sec_pulse) begin
                        if (countdown == 2'd1) begin
                            state_nx     = FIGHT;
                            countdown_nx = 2'd0;
                            controls_nx  = 1'b1;
                        end else begin
                            countdown_nx = countdown - 2'd1;
                        end
                    end
                end
                FIGHT: begin
                    // A KO code outranks a timeout landing on the same tick
                    if (hp_state != WIN_NONE || timeout) begin
                        state_nx    = ROUND_END;
                        controls_nx = 1'b0;
                        hold_nx     = '0;
                        if (hp_state == WIN_P1 || (hp_state == WIN_NONE && health_1 > health_2))
                            p1_nx = sat_inc(p1_rounds, RTW);
                        else if (hp_state == WIN_P2 || (hp_state == WIN_NONE && health_2 > health_1))
                            p2_nx = sat_inc(p2_rounds, RTW);
                    end
                end
                ROUND_END: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_nx = '0;
                        if (p1_rounds == RTW || p2_rounds == RTW || round_num == MAXR) begin
                            state_nx  = MATCH_END;
                            winner_nx = pick_winner(p1_rounds, p2_rounds, RTW);
                        end else begin
                            state_nx       = COUNTDOWN;
                            round_nx       = round_num + 3'd1;
                            countdown_nx   = COUNTDOWN_START;
                            round_reset_nx = 1'b1;
                        end
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                MATCH_END: begin
                    if (!confirm_btn)
                        hold_nx = '0;
                    else if (hold_cnt == HOLD_LAST)
                        go_title = 1'b1;
                    else
                        hold_nx = hold_cnt + 1'b1;
                end
                default: go_title = 1'b1;
            endcase

            if (force_reset && force_cnt == HOLD_LAST) begin
                go_title = 1'b1;
                force_nx = '0;
            end

            if (go_title) begin
                state_nx       = TITLE;
                countdown_nx   = 2'd0;
                p1_nx          = 3'd0;
                p2_nx          = 3'd0;
                round_nx       = 3'd1;
                winner_nx      = WIN_NONE;
                round_reset_nx = 1'b1;
                controls_nx    = 1'b0;
                hold_nx        = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= TITLE;
            countdown    <= 2'd0;
            p1_rounds    <= 3'd0;
            p2_rounds    <= 3'd0;
            round_num    <= 3'd1;
            match_winner <= WIN_NONE;
            round_reset  <= 1'b1;
            controls_en  <= 1'b0;
            hold_cnt     <= '0;
            force_cnt    <= '0;
        end else begin
            state        <= state_nx;
            countdown    <= countdown_nx;
            p1_rounds    <= p1_nx;
            p2_rounds    <= p2_nx;
            round_num    <= round_nx;
            match_winner <= winner_nx;
            round_reset  <= round_reset_nx;
            controls_en  <= controls_nx;
            hold_cnt     <= hold_nx;
            force_cnt    <= force_nx;
        end
    end

endmodule
